// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command issuer:
//   - opcode constants of the ALU_32bit_optimized partner
//   - OP_SUPPORTED: which opcodes may be issued to the ALU
//   - state encoding of the issuer FSM
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // The ALU implements the opcodes 4'b0000..4'b0111; anything above is refused.
  function automatic logic OP_SUPPORTED(input logic [3:0] op);
    return (op <= 4'b0111);
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer_if
// Command and response valid/ready channels of the ALU command issuer.
//   cmd_valid/cmd_ready/cmd_opcode/cmd_a/cmd_b/cmd_tag : command channel
//   rsp_valid/rsp_ready/rsp_result/rsp_carry/rsp_zero/rsp_err/rsp_tag : response
// modport master : the controller side (drives commands, consumes responses)
// modport slave  : the issuer side
// -----------------------------------------------------------------------------
interface alu_cmd_issuer_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int TAG_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_opcode;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [TAG_W-1:0]  cmd_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;
  logic              rsp_err;
  logic [TAG_W-1:0]  rsp_tag;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_tag
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// DEPTH x W command buffer with wrap-around pointers and an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : advance the head (ignored when empty)
//   rdata_o    : head entry (valid when !empty_o)
//   full_o     : DEPTH entries held
//   empty_o    : no entry held
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s;
  logic          pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;

  // Storage write; contents need no reset because the count qualifies them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Next pointers and count; DEPTH is a power of 2 so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
// Buffers ALU commands, issues them one at a time to the ALU with a one-cycle
// enable pulse, captures result/carry/zero after ALU_LAT cycles and returns
// them in command order.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : command and response valid/ready channels
//   alu_a/alu_b         : operands to the ALU (held between ops)
//   alu_opcode          : opcode to the ALU (held between ops)
//   alu_enable          : one-cycle pulse per issued op
//   alu_result/alu_carry_out/alu_zero_flag : ALU outputs, captured after ALU_LAT
//   busy                : FSM active or commands queued
//   done_count          : responses handed off, wraps at 2^16
// -----------------------------------------------------------------------------
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_issuer_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  input  logic              alu_zero_flag,
  output logic              busy,
  output logic [15:0]       done_count
);
  localparam int FW    = OP_W + 2 * DATA_W + TAG_W;
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              alu_en_q, alu_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [15:0]       done_q, done_d;

  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [FW-1:0]     head_s;
  logic [OP_W-1:0]   head_op_s;
  logic [DATA_W-1:0] head_a_s, head_b_s;
  logic [TAG_W-1:0]  head_tag_s;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.cmd_valid),
    .pop_i   (pop_s),
    .wdata_i ({bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_tag}),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign {head_op_s, head_a_s, head_b_s, head_tag_s} = head_s;

  assign bus.cmd_ready  = !full_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_opcode     = alu_op_q;
  assign alu_enable     = alu_en_q;
  assign done_count     = done_q;
  assign busy           = (state_q != ST_IDLE) || !empty_s;

  // FSM next state and next values of all output registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_en_d     = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_tag_d    = rsp_tag_q;
    done_d       = done_q;
    pop_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          rsp_tag_d = head_tag_s;
          if (OP_SUPPORTED(4'(head_op_s))) begin
            // Enable is registered, so it is high exactly during ISSUE.
            alu_a_d   = head_a_s;
            alu_b_d   = head_b_s;
            alu_op_d  = head_op_s;
            alu_en_d  = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            // Refused op skips the ALU entirely and answers with an error.
            rsp_err_d    = 1'b1;
            rsp_result_d = {DATA_W{1'b0}};
            rsp_carry_d  = 1'b0;
            rsp_zero_d   = 1'b0;
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter hits zero on this edge: the ALU output is now stable.
        if (cnt_q == CNT_W'(1)) begin
          rsp_result_d = alu_result;
          rsp_carry_d  = alu_carry_out;
          rsp_zero_d   = alu_zero_flag;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_d      = done_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, ALU drive and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      alu_a_q      <= {DATA_W{1'b0}};
      alu_b_q      <= {DATA_W{1'b0}};
      alu_op_q     <= {OP_W{1'b0}};
      alu_en_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {DATA_W{1'b0}};
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= {TAG_W{1'b0}};
      done_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_en_q     <= alu_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tag_q    <= rsp_tag_d;
      done_q       <= done_d;
    end
  end
endmodule
